// File: rtl/rv_core_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : rv_core_mc
// Multi-cycle RV32I core with req/gnt/rvalid instruction and data buses.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module rv_core_mc #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          CNT_W           = 32,
   parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
   input  logic             clk,
   input  logic             rstN,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_gnt,
   input  logic             imem_rvalid,
   input  logic [31:0]      imem_rdata,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [3:0]       dmem_be,
   output logic [31:0]      dmem_addr,
   output logic [31:0]      dmem_wdata,
   input  logic             dmem_gnt,
   input  logic             dmem_rvalid,
   input  logic [31:0]      dmem_rdata,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             halted,
   output logic             err
);
   typedef enum logic [2:0] {
      S_FETCH, S_IWAIT, S_EXEC, S_MREQ, S_MWAIT, S_WB, S_HALT
   } state_t;

   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
   localparam logic [6:0] OP_FENCE = 7'b0001111, OP_SYS = 7'b1110011;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d, ir_q, ir_d, ld_q, ld_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic             err_q, err_d;
   logic [31:0]      rf_q [32];

   logic [6:0]  opc, f7;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, rs1_v, rs2_v;
   assign opc   = ir_q[6:0];
   assign rd    = ir_q[11:7];
   assign f3    = ir_q[14:12];
   assign rs1   = ir_q[19:15];
   assign rs2   = ir_q[24:20];
   assign f7    = ir_q[31:25];
   assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_u = {ir_q[31:12], 12'h000};
   assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
   assign rs1_v = rf_q[rs1];
   assign rs2_v = rf_q[rs2];

   logic legal;
   always_comb begin
      legal = 1'b0;
      case (opc)
         OP_LUI, OP_AUIPC, OP_JAL, OP_FENCE: legal = 1'b1;
         OP_JALR: legal = (f3 == 3'd0);
         OP_BR:   legal = (f3 != 3'd2) && (f3 != 3'd3);
         OP_LD:   legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
         OP_ST:   legal = (f3 <= 3'd2);
         OP_IMM:  legal = (f3 == 3'd1) ? (f7 == 7'h00) :
                          (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
         OP_REG:  legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         OP_SYS:  legal = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
         default: legal = 1'b0;
      endcase
   end

   logic [31:0] alu_b, alu_y;
   assign alu_b = (opc == OP_REG) ? rs2_v : imm_i;
   always_comb begin
      alu_y = '0;
      case (f3)
         3'd0: alu_y = (opc == OP_REG && ir_q[30]) ? rs1_v - alu_b : rs1_v + alu_b;
         3'd1: alu_y = rs1_v << alu_b[4:0];
         3'd2: alu_y = {31'd0, $signed(rs1_v) < $signed(alu_b)};
         3'd3: alu_y = {31'd0, rs1_v < alu_b};
         3'd4: alu_y = rs1_v ^ alu_b;
         3'd5: alu_y = ir_q[30] ? 32'($signed(rs1_v) >>> alu_b[4:0]) : rs1_v >> alu_b[4:0];
         3'd6: alu_y = rs1_v | alu_b;
         default: alu_y = rs1_v & alu_b;
      endcase
   end

   logic        taken;
   logic [31:0] pc_plus4, next_pc;
   always_comb begin
      case (f3)
         3'd0:    taken = (rs1_v == rs2_v);
         3'd1:    taken = (rs1_v != rs2_v);
         3'd4:    taken = ($signed(rs1_v) <  $signed(rs2_v));
         3'd5:    taken = ($signed(rs1_v) >= $signed(rs2_v));
         3'd6:    taken = (rs1_v <  rs2_v);
         3'd7:    taken = (rs1_v >= rs2_v);
         default: taken = 1'b0;
      endcase
   end
   assign pc_plus4 = pc_q + 32'd4;
   always_comb begin
      next_pc = pc_plus4;
      if (legal) begin
         case (opc)
            OP_JAL:  next_pc = pc_q + imm_j;
            OP_JALR: next_pc = (rs1_v + imm_i) & ~32'd1;
            OP_BR:   next_pc = taken ? pc_q + imm_b : pc_plus4;
            default: next_pc = pc_plus4;
         endcase
      end
   end

   // Memory access: effective address, lane enables, store shift, load extend
   logic        is_store, is_mem, misaligned;
   logic [31:0] ea, lane, ld_ext;
   logic [3:0]  be;
   assign is_store   = (opc == OP_ST);
   assign is_mem     = is_store || (opc == OP_LD);
   assign ea         = rs1_v + (is_store ? imm_s : imm_i);
   assign misaligned = ((f3[1:0] == 2'd1) && ea[0]) || ((f3[1:0] == 2'd2) && (ea[1:0] != 2'd0));
   assign be         = (f3[1:0] == 2'd0) ? (4'b0001 << ea[1:0]) :
                       (f3[1:0] == 2'd1) ? (4'b0011 << ea[1:0]) : 4'b1111;
   assign lane       = dmem_rdata >> {ea[1:0], 3'b000};
   always_comb begin
      case (f3)
         3'd0:    ld_ext = {{24{lane[7]}}, lane[7:0]};
         3'd1:    ld_ext = {{16{lane[15]}}, lane[15:0]};
         3'd4:    ld_ext = {24'd0, lane[7:0]};
         3'd5:    ld_ext = {16'd0, lane[15:0]};
         default: ld_ext = lane;
      endcase
   end

   logic        rf_we;
   logic [31:0] wb_data;
   always_comb begin
      case (opc)
         OP_LD:           wb_data = ld_q;
         OP_JAL, OP_JALR: wb_data = pc_plus4;
         OP_LUI:          wb_data = imm_u;
         OP_AUIPC:        wb_data = pc_q + imm_u;
         default:         wb_data = alu_y;
      endcase
   end
   assign rf_we = (state_q == S_WB) && legal && (rd != 5'd0) &&
                  (opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL || opc == OP_JALR ||
                   opc == OP_LD  || opc == OP_IMM   || opc == OP_REG);

   always_comb begin
      state_d = state_q;  pc_d = pc_q;  ir_d = ir_q;  ld_d = ld_q;
      instret_d = instret_q;  err_d = err_q;
      imem_req = 1'b0;  dmem_req = 1'b0;  retire = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = rstN;
            if (imem_gnt) state_d = S_IWAIT;
         end
         S_IWAIT: if (imem_rvalid) begin
            ir_d    = imem_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (!legal) begin
               state_d = HALT_ON_ILLEGAL ? S_HALT : S_WB;
               err_d   = HALT_ON_ILLEGAL;
            end else if (opc == OP_SYS) begin
               state_d = S_HALT;
            end else if (next_pc[1:0] != 2'd0) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               state_d = is_mem ? S_MREQ : S_WB;
            end
         end
         S_MREQ: begin
            if (misaligned) begin
               state_d = S_HALT;
               err_d   = 1'b1;
            end else begin
               dmem_req = 1'b1;
               if (dmem_gnt) state_d = S_MWAIT;
            end
         end
         S_MWAIT: if (dmem_rvalid) begin
            if (!is_store) ld_d = ld_ext;
            state_d = S_WB;
         end
         S_WB: begin
            retire    = 1'b1;
            pc_d      = next_pc;
            instret_d = instret_q + CNT_W'(1);
            state_d   = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= S_FETCH;  pc_q <= RESET_PC;  ir_q <= '0;  ld_q <= '0;
         instret_q <= '0;  err_q <= 1'b0;
      end else begin
         state_q <= state_d;  pc_q <= pc_d;  ir_q <= ir_d;  ld_q <= ld_d;
         instret_q <= instret_d;  err_q <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      end else if (rf_we) begin
         rf_q[rd] <= wb_data;
      end
   end

   assign imem_addr  = pc_q;
   assign dmem_we    = dmem_req && is_store;
   assign dmem_be    = dmem_req ? be : 4'b0000;
   assign dmem_addr  = dmem_req ? {ea[31:2], 2'b00} : 32'd0;
   assign dmem_wdata = dmem_we ? (rs2_v << {ea[1:0], 3'b000}) : 32'd0;
   assign instret    = instret_q;
   assign halted     = (state_q == S_HALT);
   assign err        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_rv_core_mc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_rv_core_mc
// Directed bench for rv_core_mc with variable-latency memory models and scoreboards.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_rv_core_mc;
   logic        clk = 1'b0, rstN = 1'b0;
   logic        imem_req, imem_gnt, imem_rvalid, dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
   logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        retire, halted, err;
   logic [31:0] instret;

   always #5 clk = ~clk;

   rv_core_mc #(.RESET_PC(32'h0), .CNT_W(32), .HALT_ON_ILLEGAL(1'b1)) dut (
      .clk(clk), .rstN(rstN),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .retire(retire), .instret(instret), .halted(halted), .err(err)
   );

   int tests = 0, fails = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory models: gnt after *_GLAT stalled cycles, rvalid *_RLAT cycles after the earliest slot
   logic [31:0] imem [64];
   logic [7:0]  dm [512];
   int          ig_lat = 0, ir_lat = 0, dg_lat = 0, dr_lat = 0;
   int          ig_cnt, ir_cnt, dg_cnt, dr_cnt;
   logic        i_pend, d_pend, d_we;
   logic [31:0] i_addr, d_addr;

   assign imem_gnt    = imem_req && (ig_cnt >= ig_lat);
   assign imem_rvalid = i_pend && (ir_cnt >= ir_lat);
   assign imem_rdata  = imem_rvalid ? imem[i_addr[7:2]] : 32'h0;
   assign dmem_gnt    = dmem_req && (dg_cnt >= dg_lat);
   assign dmem_rvalid = d_pend && (dr_cnt >= dr_lat);
   assign dmem_rdata  = (dmem_rvalid && !d_we) ?
                        {dm[d_addr[8:0] + 3], dm[d_addr[8:0] + 2], dm[d_addr[8:0] + 1], dm[d_addr[8:0]]} : 32'h0;

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         ig_cnt <= 0; ir_cnt <= 0; i_pend <= 1'b0; i_addr <= '0;
         dg_cnt <= 0; dr_cnt <= 0; d_pend <= 1'b0; d_addr <= '0; d_we <= 1'b0;
      end else begin
         ig_cnt <= (imem_req && !imem_gnt) ? ig_cnt + 1 : 0;
         if (imem_gnt) begin i_pend <= 1'b1; ir_cnt <= 0; i_addr <= imem_addr; end
         else if (imem_rvalid) i_pend <= 1'b0;
         else if (i_pend) ir_cnt <= ir_cnt + 1;
         dg_cnt <= (dmem_req && !dmem_gnt) ? dg_cnt + 1 : 0;
         if (dmem_gnt) begin
            d_pend <= 1'b1; dr_cnt <= 0; d_addr <= dmem_addr; d_we <= dmem_we;
            if (dmem_we)
               for (int k = 0; k < 4; k++)
                  if (dmem_be[k]) dm[dmem_addr[8:0] + 9'(k)] <= dmem_wdata[8*k +: 8];
         end
         else if (dmem_rvalid) d_pend <= 1'b0;
         else if (d_pend) dr_cnt <= dr_cnt + 1;
      end
   end

   // Scoreboards
   typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} dexp_t;
   dexp_t       exp_dmem[$];
   logic [31:0] exp_fetch[$];
   int          ret_cyc[$];
   logic        i_wait_prev = 1'b0, d_wait_prev = 1'b0;
   logic [31:0] i_addr_prev, d_addr_prev;

   always @(negedge clk) begin
      if (rstN && retire) ret_cyc.push_back(cyc);
      if (rstN && imem_req && imem_gnt) begin
         tests++;
         assert (exp_fetch.size() != 0) else begin
            fails++;
            $error("FAIL fetch_unexpected observed addr=%h expected no fetch", imem_addr);
         end
         if (exp_fetch.size() != 0) check32("fetch_addr", imem_addr, exp_fetch.pop_front());
      end
      if (rstN && dmem_req && dmem_gnt) begin
         tests++;
         assert (exp_dmem.size() != 0) else begin
            fails++;
            $error("FAIL dmem_unexpected observed addr=%h expected no request", dmem_addr);
         end
         if (exp_dmem.size() != 0) begin
            dexp_t e;
            logic [31:0] m;
            e = exp_dmem.pop_front();
            m = {{8{e.be[3]}}, {8{e.be[2]}}, {8{e.be[1]}}, {8{e.be[0]}}};
            check32("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
            check32("dmem_addr", dmem_addr, e.addr);
            check32("dmem_be", {28'd0, dmem_be}, {28'd0, e.be});
            if (e.we) check32("dmem_wdata", dmem_wdata & m, e.wdata & m);
         end
      end
      if (rstN && i_wait_prev) check32("imem_stable", {imem_req, imem_addr[30:0]}, {1'b1, i_addr_prev[30:0]});
      if (rstN && d_wait_prev) check32("dmem_stable", {dmem_req, dmem_addr[30:0]}, {1'b1, d_addr_prev[30:0]});
      i_wait_prev = rstN && imem_req && !imem_gnt;
      d_wait_prev = rstN && dmem_req && !dmem_gnt;
      i_addr_prev = imem_addr;
      d_addr_prev = dmem_addr;
   end

   // Instruction encoders
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
      logic [31:0] v = imm;
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v = imm;
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] v = imm;
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
   endfunction
   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] v = imm;
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
   endfunction
   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(imm, rs1, 0, rd, 7'h13);
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 64; i++) imem[i] = 32'h0;
   endtask
   task automatic push_lin(input int n);
      for (int i = 0; i < n; i++) exp_fetch.push_back(32'(4 * i));
   endtask
   task automatic push_d(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      exp_dmem.push_back({we, a, be, wd});
   endtask

   task automatic do_reset();
      rstN = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check32("rst_outputs", {27'd0, imem_req, dmem_req, retire, halted, err}, 32'd0);
      check32("rst_instret", instret, 32'd0);
      ret_cyc.delete();
      @(posedge clk);
      #1 rstN = 1'b1;
   endtask

   task automatic run_to_halt(input string tag, input logic exp_err, input int exp_ret);
      int n = 0;
      while (!halted && n < 400) begin @(negedge clk); n++; end
      check32({tag, "_halted"}, {31'd0, halted}, 32'd1);
      repeat (6) @(negedge clk);
      check32({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
      check32({tag, "_instret"}, instret, 32'(exp_ret));
      check32({tag, "_retires"}, 32'(ret_cyc.size()), 32'(exp_ret));
      check32({tag, "_fetch_left"}, 32'(exp_fetch.size()), 32'd0);
      check32({tag, "_dmem_left"}, 32'(exp_dmem.size()), 32'd0);
   endtask

   initial begin
      int n;
      // 1: ALU pair, zero-wait timing
      clear_imem();
      imem[0] = addi(1, 0, 5);
      imem[1] = addi(2, 1, -7);
      imem[2] = enc_s(32'h40, 1, 0, 2);
      imem[3] = enc_s(32'h44, 2, 0, 2);
      imem[4] = EBREAK;
      push_lin(5);
      push_d(1'b1, 32'h40, 4'hF, 32'h0000_0005);
      push_d(1'b1, 32'h44, 4'hF, 32'hFFFF_FFFE);
      do_reset();
      n = 0;
      while (ret_cyc.size() < 2 && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
      check32("t1_instret_2", instret, 32'd2);
      run_to_halt("t1", 1'b0, 4);
      if (ret_cyc.size() == 4) begin
         check32("t1_alu_gap", 32'(ret_cyc[1] - ret_cyc[0]), 32'd4);
         check32("t1_st_gap", 32'(ret_cyc[2] - ret_cyc[1]), 32'd6);
         check32("t1_st_gap2", 32'(ret_cyc[3] - ret_cyc[2]), 32'd6);
      end

      // 2: slow instruction memory
      ig_lat = 3; ir_lat = 2;
      clear_imem();
      imem[0] = addi(1, 0, 32'h123);
      imem[1] = enc_s(32'h40, 1, 0, 2);
      imem[2] = EBREAK;
      push_lin(3);
      push_d(1'b1, 32'h40, 4'hF, 32'h0000_0123);
      do_reset();
      run_to_halt("t2", 1'b0, 2);
      if (ret_cyc.size() == 2) check32("t2_st_gap", 32'(ret_cyc[1] - ret_cyc[0]), 32'd11);
      ig_lat = 0; ir_lat = 0;

      // 3: sub-word stores and loads with slow data memory
      dg_lat = 1; dr_lat = 2;
      clear_imem();
      imem[0]  = addi(3, 0, 32'h100);
      imem[1]  = addi(1, 0, 32'h80);
      imem[2]  = enc_s(0, 1, 3, 2);
      imem[3]  = enc_s(2, 1, 3, 0);
      imem[4]  = enc_i(2, 3, 0, 4, 7'h03);
      imem[5]  = enc_i(2, 3, 4, 6, 7'h03);
      imem[6]  = enc_s(4, 4, 3, 2);
      imem[7]  = enc_s(8, 6, 3, 2);
      imem[8]  = enc_s(32'hE, 4, 3, 1);
      imem[9]  = enc_i(32'hE, 3, 5, 7, 7'h03);
      imem[10] = enc_s(32'h10, 7, 3, 2);
      imem[11] = EBREAK;
      push_lin(12);
      push_d(1'b1, 32'h100, 4'b1111, 32'h0000_0080);
      push_d(1'b1, 32'h100, 4'b0100, 32'h0080_0000);
      push_d(1'b0, 32'h100, 4'b0100, 32'h0);
      push_d(1'b0, 32'h100, 4'b0100, 32'h0);
      push_d(1'b1, 32'h104, 4'b1111, 32'hFFFF_FF80);
      push_d(1'b1, 32'h108, 4'b1111, 32'h0000_0080);
      push_d(1'b1, 32'h10C, 4'b1100, 32'hFF80_0000);
      push_d(1'b0, 32'h10C, 4'b1100, 32'h0);
      push_d(1'b1, 32'h110, 4'b1111, 32'h0000_FF80);
      do_reset();
      run_to_halt("t3", 1'b0, 11);
      dg_lat = 0; dr_lat = 0;

      // 4: branches and JAL
      clear_imem();
      imem[0] = addi(1, 0, 1);
      imem[1] = enc_b(8, 0, 1, 0);
      imem[2] = enc_j(16, 5);
      imem[5] = addi(1, 0, 0);
      imem[6] = enc_s(32'h40, 5, 0, 2);
      imem[7] = enc_b(-8, 0, 1, 1);
      imem[8] = EBREAK;
      exp_fetch = '{32'h0, 32'h4, 32'h8, 32'h18, 32'h1C, 32'h14, 32'h18, 32'h1C, 32'h20};
      push_d(1'b1, 32'h40, 4'hF, 32'h0000_000C);
      push_d(1'b1, 32'h40, 4'hF, 32'h0000_000C);
      do_reset();
      run_to_halt("t4", 1'b0, 8);

      // 5: error and halt cases
      clear_imem();
      imem[0] = addi(3, 0, 32'h100);
      imem[1] = enc_i(2, 3, 2, 4, 7'h03);
      push_lin(2);
      do_reset();
      run_to_halt("t5_misaligned_lw", 1'b1, 1);
      clear_imem();
      imem[0] = addi(1, 0, 3);
      imem[1] = EBREAK;
      push_lin(2);
      do_reset();
      run_to_halt("t5_ebreak", 1'b0, 1);
      clear_imem();
      imem[0] = addi(1, 0, 3);
      imem[1] = 32'hFFFF_FFFF;
      push_lin(2);
      do_reset();
      run_to_halt("t5_illegal", 1'b1, 1);
      clear_imem();
      imem[0] = enc_i(2, 0, 0, 1, 7'h67);
      push_lin(1);
      do_reset();
      run_to_halt("t5_bad_target", 1'b1, 0);

      // 6: reset while a load waits for data
      dr_lat = 6;
      clear_imem();
      imem[0] = addi(3, 0, 32'h100);
      imem[1] = enc_i(0, 3, 2, 4, 7'h03);
      push_lin(2);
      push_d(1'b0, 32'h100, 4'hF, 32'h0);
      do_reset();
      n = 0;
      while (exp_dmem.size() != 0 && n < 100) begin @(negedge clk); n++; end
      check32("t6_load_issued", 32'(exp_dmem.size()), 32'd0);
      repeat (2) @(negedge clk);
      check32("t6_pre_instret", instret, 32'd1);
      #1 rstN = 1'b0;
      #1;
      check32("t6_req_drop", {29'd0, imem_req, dmem_req, retire}, 32'd0);
      check32("t6_instret_clr", instret, 32'd0);
      clear_imem();
      imem[0] = enc_s(32'h40, 3, 0, 2);
      imem[1] = EBREAK;
      push_lin(2);
      push_d(1'b1, 32'h40, 4'hF, 32'h0);
      do_reset();
      run_to_halt("t6", 1'b0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
